keypad_scan_ctrl: RTL

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
//
// This block scans a 4x4 active-low matrix keypad and debounces presses and
// releases. Each accepted key shifts into a two-digit hex display. The block
// also time-multiplexes the two digits onto one shared seven-segment decoder.
//
// Parameters
//   SCAN_DIV         clk cycles each column is driven while scanning
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept press/release
//   MUX_DIV          clk cycles per display digit slot
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   rows[3:0]  keypad rows, active-low, asynchronous to clk
//   cols[3:0]  keypad column drive, active-low, exactly one bit low
//   digitL     older hex digit
//   digitR     newest hex digit
//   dispDigit  hex value for the shared decoder in the current slot
//   onSeg[1:0] digit enables, active-low; [0] = right, [1] = left
//   keyValid   one-cycle pulse per accepted key
// ---------------------------------------------------------------------------
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 2400,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int MUX_DIV         = 24000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digitL,
  output logic [3:0] digitR,
  output logic [3:0] dispDigit,
  output logic [1:0] onSeg,
  output logic       keyValid
);

  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MUX_W  = $clog2(MUX_DIV + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MUX_W-1:0]  MUX_LAST  = MUX_W'(MUX_DIV - 1);

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HOLD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  state_t            state_reg;
  logic [3:0]        sync1_reg;
  logic [3:0]        rs_reg;
  logic [1:0]        col_idx_reg;
  logic [1:0]        row_idx_reg;
  logic [3:0]        cols_reg;
  logic [SCAN_W-1:0] scan_cnt_reg;
  logic [DEB_W-1:0]  deb_cnt_reg;
  logic [MUX_W-1:0]  mux_cnt_reg;
  logic              sel_reg;
  logic [3:0]        digit_l_reg;
  logic [3:0]        digit_r_reg;
  logic              key_valid_reg;

  logic [1:0] col_next;
  logic [3:0] cols_next;
  logic       row_low;

  // Next column in the rotation and its active-low drive pattern.
  assign col_next  = col_idx_reg + 2'd1;
  assign cols_next = ~(4'b0001 << col_next);

  // The latched row as seen through the synchronizer.
  assign row_low = ~rs_reg[row_idx_reg];

  // When several rows are low at once, the lowest row index wins.
  function automatic logic [1:0] first_low(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // Keypad legend, indexed {row, col}.
  function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  4'hF: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  // Two-flop synchronizer. The idle level is all-high (pulled up).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 4'hF;
      rs_reg    <= 4'hF;
    end else begin
      sync1_reg <= rows;
      rs_reg    <= sync1_reg;
    end
  end

  // Scan / debounce FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= SCAN;
      col_idx_reg   <= 2'd0;
      row_idx_reg   <= 2'd0;
      cols_reg      <= 4'b1110;
      scan_cnt_reg  <= '0;
      deb_cnt_reg   <= '0;
      digit_l_reg   <= 4'h0;
      digit_r_reg   <= 4'h0;
      key_valid_reg <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      case (state_reg)
        SCAN: begin
          if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            if (rs_reg != 4'hF) begin
              // The current column stays driven (frozen) while this key is
              // debounced and held.
              row_idx_reg <= first_low(rs_reg);
              deb_cnt_reg <= '0;
              state_reg   <= DEB_PRESS;
            end else begin
              col_idx_reg <= col_next;
              cols_reg    <= cols_next;
            end
          end else begin
            scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
          end
        end

        DEB_PRESS: begin
          if (row_low) begin
            // Accept the key on the DEBOUNCE_CYCLES-th consecutive low cycle.
            if (deb_cnt_reg == DEB_LAST) begin
              digit_l_reg   <= digit_r_reg;
              digit_r_reg   <= decode_key(row_idx_reg, col_idx_reg);
              key_valid_reg <= 1'b1;
              deb_cnt_reg   <= '0;
              state_reg     <= HOLD;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
          end else begin
            // A bounce abandons the candidate and moves on to the next column.
            deb_cnt_reg  <= '0;
            scan_cnt_reg <= '0;
            col_idx_reg  <= col_next;
            cols_reg     <= cols_next;
            state_reg    <= SCAN;
          end
        end

        HOLD: begin
          // Only the latched row is watched, so other keys cannot register.
          if (!row_low) begin
            deb_cnt_reg <= '0;
            state_reg   <= DEB_REL;
          end
        end

        DEB_REL: begin
          if (!row_low) begin
            if (deb_cnt_reg == DEB_LAST) begin
              deb_cnt_reg  <= '0;
              scan_cnt_reg <= '0;
              col_idx_reg  <= col_next;
              cols_reg     <= cols_next;
              state_reg    <= SCAN;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
          end else begin
            deb_cnt_reg <= '0;
            state_reg   <= HOLD;
          end
        end

        default: state_reg <= SCAN;
      endcase
    end
  end

  // The display multiplexer runs freely, independent of the FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mux_cnt_reg <= '0;
      sel_reg     <= 1'b0;
    end else if (mux_cnt_reg == MUX_LAST) begin
      mux_cnt_reg <= '0;
      sel_reg     <= ~sel_reg;
    end else begin
      mux_cnt_reg <= mux_cnt_reg + MUX_W'(1);
    end
  end

  assign cols      = cols_reg;
  assign digitL    = digit_l_reg;
  assign digitR    = digit_r_reg;
  assign keyValid  = key_valid_reg;
  assign onSeg     = sel_reg ? 2'b01 : 2'b10;
  // dispDigit is taken directly from the digit registers, so a digit update
  // that lands on a slot toggle is shown as soon as the registers change.
  assign dispDigit = sel_reg ? digit_l_reg : digit_r_reg;

endmodule
